// File: rtl/latch_ctrl_pkg.sv
// Shared types and default parameter values for the latch-bank write controller.
package latch_ctrl_pkg;

    localparam int unsigned NUM_LATCH_DEF = 4;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned EN_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

endpackage

// File: rtl/latch_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: masked requesters are ignored, ties go to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] elig;

    always_comb begin
        elig  = req & ~mask;
        grant = '0;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Serialises writes from two requesters into a latch bank: set up D, pulse one
// enable for EN_CYCLES clocks, then hold one cycle and acknowledge.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LATCH = NUM_LATCH_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned EN_CYCLES = EN_CYCLES_DEF,
    localparam int unsigned AW       = $clog2(NUM_LATCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [AW-1:0]        addr0,
    input  logic [DW-1:0]        data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        data1,
    output logic                 ack1,
    output logic [NUM_LATCH-1:0] lat_en,
    output logic [DW-1:0]        lat_d,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(EN_CYCLES + 1);

    state_t          state, state_nxt;
    logic            gid_q;
    logic            last_q;
    logic            just_acked_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      mask;
    logic [1:0]      grant;

    // Requester acked in the previous cycle sits out exactly one IDLE cycle.
    assign mask = just_acked_q ? (gid_q ? 2'b10 : 2'b01) : 2'b00;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_q),
        .mask       (mask),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_en    = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:  if (|grant) state_nxt = SETUP;
            SETUP: state_nxt = PULSE;
            PULSE: begin
                lat_en[addr_q] = 1'b1;
                if (cnt_q == CW'(EN_CYCLES - 1)) state_nxt = HOLD;
            end
            HOLD: begin
                ack0      = ~gid_q;
                ack1      = gid_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid_q        <= 1'b0;
            last_q       <= 1'b1;
            just_acked_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            just_acked_q <= (state == HOLD);
            if (state == IDLE && |grant) begin
                gid_q  <= grant[1];
                last_q <= grant[1];
                addr_q <= grant[1] ? addr1 : addr0;
                data_q <= grant[1] ? data1 : data0;
            end
            if (state == PULSE) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign lat_d = data_q;

endmodule
